// File: rtl/data_demux_pkg.sv
// Shared types and helpers for the link receive-side demultiplexer.
package data_demux_pkg;

    localparam int unsigned MAX_DATA_WIDTH = 64;
    localparam int unsigned SEL_WIDTH      = 4;
    localparam int unsigned CNT_WIDTH      = 16;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } demux_state_t;

    // Full-width mirror; callers zero-extend into the low bits and shift the result down.
    function automatic logic [MAX_DATA_WIDTH-1:0] bit_reverse(input logic [MAX_DATA_WIDTH-1:0] v);
        logic [MAX_DATA_WIDTH-1:0] r;
        for (int unsigned i = 0; i < MAX_DATA_WIDTH; i++) begin
            r[i] = v[MAX_DATA_WIDTH-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/data_demux_impl_route_reg.sv
// One-entry AXIS holding register whose valid is stored one-hot per destination.
module axis_route_reg
    import data_demux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_OUTPUTS  = 2
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 flush_i,
    input  logic                                 load_i,
    input  logic [DATA_WIDTH-1:0]                load_data_i,
    input  logic [SEL_WIDTH-1:0]                 load_dest_i,
    input  logic [N_OUTPUTS-1:0]                 tready_out,
    output logic [N_OUTPUTS-1:0][DATA_WIDTH-1:0] tdata_out,
    output logic [N_OUTPUTS-1:0]                 tvalid_out,
    output logic                                 space_o
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [N_OUTPUTS-1:0]  valid_q, valid_d;
    logic                  unload_s;

    assign unload_s = |(valid_q & tready_out);
    assign space_o  = ~(|valid_q) | unload_s;

    // Next register contents: flush beats load beats unload.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = '0;
        end else if (load_i) begin
            data_d = load_data_i;
            for (int unsigned i = 0; i < N_OUTPUTS; i++) begin
                valid_d[i] = (load_dest_i == SEL_WIDTH'(i));
            end
        end else if (unload_s) begin
            valid_d = '0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Holding register state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    for (genvar g = 0; g < N_OUTPUTS; g++) begin : g_out
        assign tdata_out[g] = data_q;
    end
    assign tvalid_out = valid_q;

endmodule

// File: rtl/data_demux_impl.sv
// Link receive demux: locks on a run of idle words, then strips idles and routes
// payload words to one of N_OUTPUTS AXIS consumers.
module data_demux_impl
    import data_demux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned N_OUTPUTS          = 2,
    parameter int unsigned INPUT_REVERSE_BITS = 1
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic [DATA_WIDTH-1:0]                tdata_in,
    input  logic                                 tvalid_in,
    output logic                                 tready_in,
    output logic [N_OUTPUTS-1:0][DATA_WIDTH-1:0] tdata_out,
    output logic [N_OUTPUTS-1:0]                 tvalid_out,
    input  logic [N_OUTPUTS-1:0]                 tready_out,
    input  logic [CNT_WIDTH-1:0]                 n_idle_words,
    input  logic [SEL_WIDTH-1:0]                 output_select,
    input  logic [DATA_WIDTH-1:0]                idle_word,
    input  logic                                 fc_linkReset,
    output logic                                 locked,
    output logic [CNT_WIDTH-1:0]                 n_dropped
);

    demux_state_t          state_q, state_d;
    logic [CNT_WIDTH-1:0]  idle_cnt_q, idle_cnt_d;
    logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
    logic                  run_q;
    logic [DATA_WIDTH-1:0] word_s;
    logic                  is_idle_s;
    logic                  accept_s;
    logic                  sel_ok_s;
    logic                  load_s;
    logic                  space_s;

    if (INPUT_REVERSE_BITS != 0) begin : g_rev
        assign word_s = DATA_WIDTH'(bit_reverse(MAX_DATA_WIDTH'(tdata_in)) >> (MAX_DATA_WIDTH - DATA_WIDTH));
    end else begin : g_norev
        assign word_s = tdata_in;
    end

    assign is_idle_s = (word_s == idle_word);
    assign accept_s  = tvalid_in & tready_in;
    assign sel_ok_s  = ({1'b0, output_select} < (SEL_WIDTH + 1)'(N_OUTPUTS));
    assign load_s    = (state_q == LOCKED) & accept_s & ~is_idle_s & sel_ok_s;

    // run_q holds ready low until the first clock after reset release.
    assign tready_in = run_q & ~fc_linkReset & ((state_q == SEARCH) | space_s);
    assign locked    = (state_q == LOCKED);
    assign n_dropped = drop_cnt_q;

    // Lock FSM, idle-run counter and drop counter next state.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (fc_linkReset) begin
            state_d    = SEARCH;
            idle_cnt_d = '0;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (n_idle_words == 16'd0) begin
                        state_d    = LOCKED;
                        idle_cnt_d = '0;
                    end else if (accept_s && is_idle_s) begin
                        // >= rather than == so a threshold lowered mid-run still ends the count.
                        if (({1'b0, idle_cnt_q} + 17'd1) >= {1'b0, n_idle_words}) begin
                            state_d    = LOCKED;
                            idle_cnt_d = '0;
                        end else begin
                            idle_cnt_d = idle_cnt_q + 16'd1;
                        end
                    end else if (accept_s) begin
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q;
                    end
                end
                LOCKED: begin
                    if (accept_s && !is_idle_s && !sel_ok_s && (drop_cnt_q != 16'hFFFF)) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end else begin
                        drop_cnt_d = drop_cnt_q;
                    end
                end
                default: begin
                    state_d    = SEARCH;
                    idle_cnt_d = '0;
                end
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= SEARCH;
            idle_cnt_q <= '0;
            drop_cnt_q <= '0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            run_q      <= 1'b1;
        end
    end

    axis_route_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_OUTPUTS  (N_OUTPUTS)
    ) u_route_reg (
        .clk         (clk),
        .resetn      (resetn),
        .flush_i     (fc_linkReset),
        .load_i      (load_s),
        .load_data_i (word_s),
        .load_dest_i (output_select),
        .tready_out  (tready_out),
        .tdata_out   (tdata_out),
        .tvalid_out  (tvalid_out),
        .space_o     (space_s)
    );

endmodule

// File: tb/tb_data_demux_impl.sv
// Directed bench for data_demux_impl (32-bit words, 2 outputs, input bit reversal on).
module tb_data_demux_impl;

    logic             clk = 1'b0;
    logic             resetn;
    logic [31:0]      tdata_in;
    logic             tvalid_in;
    logic             tready_in;
    logic [1:0][31:0] tdata_out;
    logic [1:0]       tvalid_out;
    logic [1:0]       tready_out;
    logic [15:0]      n_idle_words;
    logic [3:0]       output_select;
    logic [31:0]      idle_word;
    logic             fc_linkReset;
    logic             locked;
    logic [15:0]      n_dropped;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] idle_rx;

    data_demux_impl #(
        .DATA_WIDTH         (32),
        .N_OUTPUTS          (2),
        .INPUT_REVERSE_BITS (1)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .tdata_in      (tdata_in),
        .tvalid_in     (tvalid_in),
        .tready_in     (tready_in),
        .tdata_out     (tdata_out),
        .tvalid_out    (tvalid_out),
        .tready_out    (tready_out),
        .n_idle_words  (n_idle_words),
        .output_select (output_select),
        .idle_word     (idle_word),
        .fc_linkReset  (fc_linkReset),
        .locked        (locked),
        .n_dropped     (n_dropped)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] w);
        tdata_in  = rev32(w);
        tvalid_in = 1'b1;
        step();
    endtask

    initial begin
        idle_rx       = rev32(32'hACCCCCCC);
        resetn        = 1'b0;
        tdata_in      = 32'h0;
        tvalid_in     = 1'b0;
        tready_out    = 2'b00;
        n_idle_words  = 16'd4;
        output_select = 4'd1;
        idle_word     = 32'hACCCCCCC;
        fc_linkReset  = 1'b0;
        step();
        step();
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_tvalid_out", 32'(tvalid_out), 32'd0);
        chk("rst_tready_in", 32'(tready_in), 32'd0);
        chk("rst_n_dropped", 32'(n_dropped), 32'd0);
        chk("rst_tdata_out1", tdata_out[1], 32'h0);
        resetn = 1'b1;
        step();
        chk("ready_after_release", 32'(tready_in), 32'd1);

        // Lock: 3 idles, a payload that restarts the count, then 4 idles.
        send(32'hACCCCCCC); send(32'hACCCCCCC); send(32'hACCCCCCC);
        send(32'h12345678);
        send(32'hACCCCCCC); send(32'hACCCCCCC); send(32'hACCCCCCC);
        chk("lock_after_7", 32'(locked), 32'd0);
        send(32'hACCCCCCC);
        chk("lock_after_8", 32'(locked), 32'd1);
        chk("lock_no_output", 32'(tvalid_out), 32'd0);

        // Route to output 1 back-to-back.
        output_select = 4'd1;
        tready_out    = 2'b10;
        send(32'h1);
        chk("route_v1", 32'(tvalid_out), 32'h2);
        chk("route_d1", tdata_out[1], 32'h1);
        send(32'h2);
        chk("route_v2", 32'(tvalid_out), 32'h2);
        chk("route_d2", tdata_out[1], 32'h2);
        send(32'h3);
        chk("route_d3", tdata_out[1], 32'h3);
        tvalid_in = 1'b0;
        step();
        chk("route_drained", 32'(tvalid_out), 32'd0);

        // Backpressure on output 0.
        output_select = 4'd0;
        tready_out    = 2'b00;
        send(32'h11);
        chk("bp_v_first", 32'(tvalid_out), 32'h1);
        tdata_in = rev32(32'h22);
        #1;
        chk("bp_ready_low", 32'(tready_in), 32'd0);
        for (int i = 0; i < 4; i++) step();
        chk("bp_data_held", tdata_out[0], 32'h11);
        chk("bp_valid_held", 32'(tvalid_out), 32'h1);
        tready_out = 2'b01;
        #1;
        chk("bp_ready_release", 32'(tready_in), 32'd1);
        step();
        chk("bp_second_word", tdata_out[0], 32'h22);
        chk("bp_second_valid", 32'(tvalid_out), 32'h1);
        tvalid_in = 1'b0;
        step();
        chk("bp_drained", 32'(tvalid_out), 32'd0);

        // Bad select drops payload words only.
        output_select = 4'd5;
        tready_out    = 2'b11;
        send(32'hA1);
        chk("bad_no_valid", 32'(tvalid_out), 32'd0);
        send(32'hA2);
        send(32'hA3);
        chk("bad_dropped3", 32'(n_dropped), 32'd3);
        send(32'hACCCCCCC);
        send(32'hACCCCCCC);
        tvalid_in = 1'b0;
        step();
        chk("bad_idles_not_counted", 32'(n_dropped), 32'd3);
        chk("bad_no_valid_end", 32'(tvalid_out), 32'd0);

        // Link reset with a word stuck in the register.
        output_select = 4'd0;
        tready_out    = 2'b00;
        send(32'h77);
        tvalid_in = 1'b0;
        chk("lr_pending", 32'(tvalid_out), 32'h1);
        fc_linkReset = 1'b1;
        #1;
        chk("lr_ready_low", 32'(tready_in), 32'd0);
        step();
        fc_linkReset = 1'b0;
        chk("lr_unlocked", 32'(locked), 32'd0);
        chk("lr_discarded", 32'(tvalid_out), 32'd0);
        send(32'hACCCCCCC); send(32'hACCCCCCC); send(32'hACCCCCCC);
        chk("lr_relock_3", 32'(locked), 32'd0);
        send(32'hACCCCCCC);
        chk("lr_relock_4", 32'(locked), 32'd1);

        // Asynchronous reset while locked with a word pending.
        output_select = 4'd1;
        send(32'h99);
        tvalid_in = 1'b0;
        chk("ar_pending", 32'(tvalid_out), 32'h2);
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_locked", 32'(locked), 32'd0);
        chk("ar_tvalid_out", 32'(tvalid_out), 32'd0);
        chk("ar_tdata_out1", tdata_out[1], 32'h0);
        chk("ar_tready_in", 32'(tready_in), 32'd0);
        chk("ar_n_dropped", 32'(n_dropped), 32'd0);
        step();
        resetn = 1'b1;
        step();
        chk("ar_search", 32'(locked), 32'd0);
        chk("ar_ready", 32'(tready_in), 32'd1);

        // Zero idle threshold locks without any words.
        n_idle_words = 16'd0;
        step();
        chk("zero_idle_lock", 32'(locked), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
